// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T0-T7 control sequencer driving Datapath2 strobes.
// Optional SINGLE_STEP_EN adds a STEP hold state and the step input.
module control_sequencer #(
  parameter int         MEM_WAIT  = 1,
  parameter logic [4:0] ALU_INCPC = 5'd12,
  parameter logic [4:0] ALU_ADD   = 5'd2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        InportOut,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Rin,
  output logic        CONin,
  output logic        OutportIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  OpCode,
  output logic        run
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T6W, S_T7, S_HALT, S_STEP
  } state_t;

  state_t     state, state_next, done_state;
  logic [2:0] wait_cnt;
  logic       step_go;

  logic [4:0] op;
  logic       is_ld, is_ldi, is_st, is_mem, is_rtype, is_itype;
  logic       is_br, is_jr, is_jal, is_in, is_out, is_halt;
  logic       read_state;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_ld     = (op == 5'b00000);
  assign is_ldi    = (op == 5'b00001);
  assign is_st     = (op == 5'b00010);
  assign is_mem    = is_ld | is_ldi | is_st;
  assign is_rtype  = (op >= 5'b00011) && (op <= 5'b01011);
  assign is_itype  = (op >= 5'b01100) && (op <= 5'b01110);
  assign is_br     = (op == 5'b10011);
  assign is_jr     = (op == 5'b10100);
  assign is_jal    = (op == 5'b10101);
  assign is_in     = (op == 5'b10110);
  assign is_out    = (op == 5'b10111);
  assign is_halt   = (op == 5'b11011);

  // Cycles during which memory is being read; the wait counter reloads outside them.
  assign read_state = (state == S_T1) || (state == S_T1W) || (state == S_T6W) ||
                      ((state == S_T6) && is_ld);

`ifdef SINGLE_STEP_EN
  logic step_armed;

  // step must be seen low between advances, so a held-high step runs one instruction.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                   step_armed <= 1'b0;
    else if (!step)            step_armed <= 1'b1;
    else if (state == S_STEP)  step_armed <= 1'b0;
  end

  assign step_go    = (state == S_STEP) && step && step_armed;
  assign done_state = S_STEP;
`else
  assign step_go    = 1'b0;
  assign done_state = S_T0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_T0;
      wait_cnt <= 3'd0;
    end else begin
      state <= state_next;
      if (!read_state)          wait_cnt <= WAIT_INIT;
      else if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_T0:        state_next = S_T1;
      S_T1, S_T1W: state_next = (wait_cnt == 3'd0) ? S_T2 : S_T1W;
      S_T2:        state_next = S_T3;
      S_T3: begin
        if (is_halt)                                            state_next = S_HALT;
        else if (is_mem || is_rtype || is_itype || is_br || is_jal) state_next = S_T4;
        else                                                    state_next = done_state;
      end
      S_T4:  state_next = (is_mem || is_rtype || is_itype || is_br) ? S_T5 : done_state;
      S_T5:  state_next = (is_ld || is_st || is_br) ? S_T6 : done_state;
      S_T6: begin
        if (is_ld)      state_next = (wait_cnt == 3'd0) ? S_T7 : S_T6W;
        else if (is_st) state_next = S_T7;
        else            state_next = done_state;
      end
      S_T6W:  state_next = (wait_cnt == 3'd0) ? S_T7 : S_T6W;
      S_T7:   state_next = done_state;
      S_HALT: state_next = S_HALT;
      S_STEP: state_next = step_go ? S_T0 : S_STEP;
      default: state_next = S_T0;
    endcase
  end

  always_comb begin
    {PCout, Zlowout, MDRout, Cout, BAout, Rout, InportOut} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn} = '0;
    {Gra, Grb, Grc, Read, Write} = '0;
    OpCode = 5'd0;
    run    = clr || (state != S_HALT);
    // Strobes are held off while clr is asserted; T0 strobes appear once it drops.
    if (!clr) begin
      case (state)
        S_T0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; OpCode = ALU_INCPC; end
        S_T1: begin
          Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = (wait_cnt == 3'd0);
        end
        S_T1W, S_T6W: begin Read = 1'b1; MDRin = (wait_cnt == 3'd0); end
        S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
        S_T3: begin
          if (is_mem)                     begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          else if (is_rtype || is_itype)  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          else if (is_br)                 begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          else if (is_jr)                 begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          else if (is_jal)                begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          else if (is_in)                 begin InportOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          else if (is_out)                begin Gra = 1'b1; Rout = 1'b1; OutportIn = 1'b1; end
        end
        S_T4: begin
          if (is_mem)         begin Cout = 1'b1; OpCode = ALU_ADD; Zin = 1'b1; end
          else if (is_rtype)  begin Grc = 1'b1; Rout = 1'b1; OpCode = op; Zin = 1'b1; end
          else if (is_itype)  begin Cout = 1'b1; OpCode = op; Zin = 1'b1; end
          else if (is_br)     begin PCout = 1'b1; Yin = 1'b1; end
          else if (is_jal)    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        end
        S_T5: begin
          if (is_ld || is_st)                      begin Zlowout = 1'b1; MARin = 1'b1; end
          else if (is_ldi || is_rtype || is_itype) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          else if (is_br)                          begin Cout = 1'b1; OpCode = ALU_ADD; Zin = 1'b1; end
        end
        S_T6: begin
          if (is_ld)              begin Read = 1'b1; MDRin = (wait_cnt == 3'd0); end
          else if (is_st)         begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          else if (is_br && con_ff) begin Zlowout = 1'b1; PCin = 1'b1; end
        end
        S_T7: begin
          if (is_ld)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          else if (is_st) Write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  a_one_bus_source: assert property (@(posedge clk) disable iff (clr)
    $onehot0({PCout, Zlowout, MDRout, Cout, BAout, Rout, InportOut}));
  a_no_read_write: assert property (@(posedge clk) disable iff (clr) !(Read && Write));

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - table, random and corner-case checks for control_sequencer.
module tb_control_sequencer;
  localparam int MW = 2;

  typedef logic [26:0] sv_t;
  localparam sv_t WR  = sv_t'(1) << 0,  RD  = sv_t'(1) << 1,  GRC = sv_t'(1) << 2;
  localparam sv_t GRB = sv_t'(1) << 3,  GRA = sv_t'(1) << 4,  OPI = sv_t'(1) << 5;
  localparam sv_t CNI = sv_t'(1) << 6,  RIN = sv_t'(1) << 7,  ZIN = sv_t'(1) << 8;
  localparam sv_t YIN = sv_t'(1) << 9,  IRI = sv_t'(1) << 10, MDI = sv_t'(1) << 11;
  localparam sv_t MAI = sv_t'(1) << 12, PCI = sv_t'(1) << 13, INO = sv_t'(1) << 14;
  localparam sv_t RO  = sv_t'(1) << 15, BAO = sv_t'(1) << 16, CO  = sv_t'(1) << 17;
  localparam sv_t MDO = sv_t'(1) << 18, ZLO = sv_t'(1) << 19, PCO = sv_t'(1) << 20;
  localparam sv_t RUN = sv_t'(1) << 21;

  logic clk = 1'b0, clr = 1'b1, con_ff = 1'b0;
  logic [31:0] ir = 32'd0;
`ifdef SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  logic PCout, Zlowout, MDRout, Cout, BAout, Rout, InportOut;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn;
  logic Gra, Grb, Grc, Read, Write, run;
  logic [4:0] OpCode;
  sv_t obs;

  int n_cmp = 0, n_bad = 0;
  sv_t exp_q[$];

  typedef struct {
    logic [31:0] ir;
    bit          cff;
    int          idx;
    sv_t         want;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  control_sequencer #(.MEM_WAIT(MW), .ALU_INCPC(5'd12), .ALU_ADD(5'd2)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
    .Rout(Rout), .InportOut(InportOut), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Rin(Rin), .CONin(CONin), .OutportIn(OutportIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write), .OpCode(OpCode), .run(run)
  );

  assign obs = {OpCode, run, PCout, Zlowout, MDRout, Cout, BAout, Rout, InportOut,
                PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn,
                Gra, Grb, Grc, Read, Write};

  function automatic sv_t opf(input logic [4:0] o);
    return sv_t'(o) << 22;
  endfunction

  // Memory read: first cycle carries `extra`, Read spans MW+1 cycles, MDRin on the last.
  task automatic push_read(input sv_t extra);
    for (int k = 0; k <= MW; k++)
      exp_q.push_back(RUN | RD | ((k == 0) ? extra : '0) | ((k == MW) ? MDI : '0));
  endtask

  task automatic model(input logic [31:0] irv, input bit cff);
    int o;
    o = int'(irv[31:27]);
    exp_q.delete();
    exp_q.push_back(RUN | PCO | MAI | ZIN | opf(5'd12));
    push_read(ZLO | PCI);
    exp_q.push_back(RUN | MDO | IRI);
    if (o <= 2) begin
      exp_q.push_back(RUN | GRB | BAO | YIN);
      exp_q.push_back(RUN | CO | ZIN | opf(5'd2));
      if (o == 1) exp_q.push_back(RUN | ZLO | GRA | RIN);
      else begin
        exp_q.push_back(RUN | ZLO | MAI);
        if (o == 0) begin
          push_read('0);
          exp_q.push_back(RUN | MDO | GRA | RIN);
        end else begin
          exp_q.push_back(RUN | GRA | RO | MDI);
          exp_q.push_back(RUN | WR);
        end
      end
    end else if (o <= 14) begin
      exp_q.push_back(RUN | GRB | RO | YIN);
      exp_q.push_back(RUN | ((o <= 11) ? (GRC | RO) : CO) | ZIN | opf(5'(o)));
      exp_q.push_back(RUN | ZLO | GRA | RIN);
    end else if (o == 19) begin
      exp_q.push_back(RUN | GRA | RO | CNI);
      exp_q.push_back(RUN | PCO | YIN);
      exp_q.push_back(RUN | CO | ZIN | opf(5'd2));
      exp_q.push_back(RUN | (cff ? (ZLO | PCI) : '0));
    end else if (o == 20) exp_q.push_back(RUN | GRA | RO | PCI);
    else if (o == 21) begin
      exp_q.push_back(RUN | PCO | GRB | RIN);
      exp_q.push_back(RUN | GRA | RO | PCI);
    end else if (o == 22) exp_q.push_back(RUN | INO | GRA | RIN);
    else if (o == 23) exp_q.push_back(RUN | GRA | RO | OPI);
    else exp_q.push_back(RUN);
  endtask

  task automatic chk(input string nm, input sv_t want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, obs, want);
    end
  endtask

  // Entered just after a negedge with the DUT in T0; n<0 runs the whole instruction.
  task automatic run_instr(input logic [31:0] irv, input bit cff, input int n,
                           input int tidx, input sv_t tvec, input bit auto_step);
    int lim;
    ir = irv;
    con_ff = cff;
    model(irv, cff);
    #1;
    lim = (n < 0) ? exp_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk($sformatf("op%0d_cyc%0d", irv[31:27], i), exp_q[i]);
      if (i == tidx) chk($sformatf("table_op%0d_cyc%0d", irv[31:27], i), tvec);
    end
    if (n < 0) begin
      @(negedge clk);
`ifdef SINGLE_STEP_EN
      if (auto_step && irv[31:27] != 5'b11011) begin
        #1;
        chk("step_hold", RUN);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
      end
`else
      if (auto_step) ;
`endif
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    chk("reset_outputs", RUN);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rir;
    logic [4:0]  rop;
    tbl[0]  = '{32'h18A20000, 1'b0, 6,  RUN | GRC | RO | ZIN | opf(5'b00011)};
    tbl[1]  = '{32'h18A20000, 1'b0, 7,  RUN | ZLO | GRA | RIN};
    tbl[2]  = '{32'h00800075, 1'b0, 10, RUN | RD | MDI};
    tbl[3]  = '{32'h00800075, 1'b0, 9,  RUN | RD};
    tbl[4]  = '{32'h00800075, 1'b0, 3,  RUN | RD | MDI};
    tbl[5]  = '{32'h98000000, 1'b0, 8,  RUN};
    tbl[6]  = '{32'h98000000, 1'b1, 8,  RUN | ZLO | PCI};
    tbl[7]  = '{32'h10000000, 1'b0, 9,  RUN | WR};
    tbl[8]  = '{32'hA8000000, 1'b0, 5,  RUN | PCO | GRB | RIN};
    tbl[9]  = '{32'h08000000, 1'b0, 7,  RUN | ZLO | GRA | RIN};
    tbl[10] = '{32'h60000000, 1'b0, 6,  RUN | CO | ZIN | opf(5'd12)};
    tbl[11] = '{32'hF8000000, 1'b0, 5,  RUN};
    tbl[12] = '{32'hD0000000, 1'b0, 5,  RUN};

    @(negedge clk);
    do_reset();

    for (int t = 0; t < 13; t++)
      run_instr(tbl[t].ir, tbl[t].cff, -1, tbl[t].idx, tbl[t].want, 1'b1);

    for (int r = 0; r < 200; r++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'b11011) rop = 5'b11010;
      rir = {rop, 27'($urandom)};
      run_instr(rir, 1'($urandom_range(0, 1)), -1, -1, '0, 1'b1);
    end

    // clr pulse while an add sits in T4
    run_instr(32'h18A20000, 1'b0, 7, 6, RUN | GRC | RO | ZIN | opf(5'b00011), 1'b0);
    clr = 1'b1;
    #1;
    chk("clr_mid_t4", RUN);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("t0_after_clr", RUN | PCO | MAI | ZIN | opf(5'd12));
    @(negedge clk);
    do_reset();

    // halt: run drops, strobes stay off until clr
    run_instr(32'hD8000000, 1'b0, -1, -1, '0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      #1;
      chk($sformatf("halted_cyc%0d", c), '0);
      @(negedge clk);
    end
    do_reset();
    run_instr(32'h18A20000, 1'b0, -1, 6, RUN | GRC | RO | ZIN | opf(5'b00011), 1'b1);

`ifdef SINGLE_STEP_EN
    do_reset();
    run_instr(32'hD0000000, 1'b0, -1, -1, '0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("step_idle%0d", c), RUN);
      @(negedge clk);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    run_instr(32'hD0000000, 1'b0, -1, -1, '0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("step_one_only%0d", c), RUN);
      @(negedge clk);
    end
    step = 1'b1;
    @(negedge clk);
    run_instr(32'hD0000000, 1'b0, -1, -1, '0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("step_held_high%0d", c), RUN);
      @(negedge clk);
    end
    step = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
